// File: rtl/ddr_refresh_sched.sv
// Periodic DDR auto-refresh scheduler: times tREFI, tracks owed refreshes with
// bounded postponement and issues PRECHARGE-all followed by AUTO REFRESH bursts.
module ddr_refresh_sched #(
    parameter int unsigned BA_BITS      = 2,
    parameter int unsigned ROW_BITS     = 13,
    parameter int unsigned TREFI_CYC    = 780,
    parameter int unsigned TRP_CYC      = 2,
    parameter int unsigned TRFC_CYC     = 8,
    parameter int unsigned MAX_POSTPONE = 8
) (
    input  logic                core_clk,
    input  logic                core_rst_sync,
    input  logic                init_done,
    input  logic                ref_grant,
    output logic                ref_req,
    output logic                ref_urgent,
    output logic                ref_busy,
    output logic                ref_done,
    output logic                ref_overflow,
    output logic [3:0]          ref_pending,
    output logic                ddr_cs_n,
    output logic                ddr_ras_n,
    output logic                ddr_cas_n,
    output logic                ddr_we_n,
    output logic [BA_BITS-1:0]  ddr_ba,
    output logic [ROW_BITS-1:0] ddr_a
);

    localparam int unsigned IVL_W    = $clog2(TREFI_CYC);
    localparam int unsigned WAIT_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [3:0]  PEND_MAX = 4'(MAX_POSTPONE);
    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_REF  = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        PRE_WAIT,
        REF,
        REF_WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_next;
    logic [IVL_W-1:0]    ivl_cnt;
    logic                init_q;
    logic                wrap;
    logic [3:0]          pending;
    logic [3:0]          pending_next;
    logic [3:0]          cmd;
    logic                a10;

    // Counting starts the cycle after init_done is first sampled, so the first
    // wrap lands TREFI_CYC edges after that sample.
    assign wrap = init_done && init_q && (ivl_cnt == IVL_W'(TREFI_CYC - 1));

    // Saturating increment on wrap, decrement per REFRESH issued.
    always_comb begin
        pending_next = pending;
        if (wrap && (pending != PEND_MAX)) begin
            pending_next = pending_next + 4'd1;
        end
        if ((state == REF) && (pending != 4'd0)) begin
            pending_next = pending_next - 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        case (state)
            IDLE: begin
                if (ref_req && ref_grant) begin
                    state_next = PRE;
                end
            end
            PRE: begin
                state_next = PRE_WAIT;
                wait_next  = '0;
            end
            PRE_WAIT: begin
                if (wait_cnt == WAIT_W'(TRP_CYC - 1)) begin
                    state_next = REF;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            REF: begin
                state_next = REF_WAIT;
                wait_next  = '0;
            end
            REF_WAIT: begin
                if (wait_cnt == WAIT_W'(TRFC_CYC - 1)) begin
                    state_next = ((pending != 4'd0) && ref_grant) ? REF : DONE;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!init_done) begin
            state_next = IDLE;
            wait_next  = '0;
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst_sync) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            ivl_cnt      <= '0;
            init_q       <= 1'b0;
            pending      <= '0;
            ref_overflow <= 1'b0;
            ref_busy     <= 1'b0;
            ref_done     <= 1'b0;
            cmd          <= CMD_NOP;
            a10          <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            init_q   <= init_done;
            ref_busy <= (state_next != IDLE);
            ref_done <= (state_next == DONE);
            case (state_next)
                PRE: begin
                    cmd <= CMD_PRE;
                    a10 <= 1'b1;
                end
                REF: begin
                    cmd <= CMD_REF;
                    a10 <= 1'b0;
                end
                default: begin
                    cmd <= CMD_NOP;
                    a10 <= 1'b0;
                end
            endcase
            if (!init_done) begin
                ivl_cnt <= '0;
                pending <= '0;
            end else begin
                pending <= pending_next;
                if (wrap) begin
                    ivl_cnt <= '0;
                end else if (init_q) begin
                    ivl_cnt <= ivl_cnt + IVL_W'(1);
                end
            end
            if (wrap && (pending == PEND_MAX)) begin
                ref_overflow <= 1'b1;
            end
        end
    end

    assign ref_req     = (pending != 4'd0);
    assign ref_urgent  = (pending >= 4'(MAX_POSTPONE - 1));
    assign ref_pending = pending;
    assign {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = cmd;
    assign ddr_ba      = '0;

    always_comb begin
        ddr_a     = '0;
        ddr_a[10] = a10;
    end

endmodule
